mem_port_arbiter: RTL

//  Shares the single 128-bit block memory port between the I-cache (read-only) and the D-cache (read/write).

---
 rtl/mem_port_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares one 128-bit block memory port between the I-cache and
//                the D-cache. Round-robin or fixed D-priority on collision.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W    = 28,
    parameter int DATA_W    = 128,
    parameter int FIXED_PRI = 0
) (
    input  logic              clk,
    input  logic              proc_reset_n,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [31:0]       i_grants,
    output logic [31:0]       d_grants
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GNT_I   = 2'd1,
        ST_GNT_D   = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    localparam logic C_LAST_I = 1'b0;
    localparam logic C_LAST_D = 1'b1;

    state_t      r_state;
    logic        r_last;
    logic [31:0] r_i_grants;
    logic [31:0] r_d_grants;

    logic w_i_req;
    logic w_d_req;
    logic w_gnt_i;
    logic w_gnt_d;
    logic w_pick_d;

    assign w_i_req = i_read;
    assign w_d_req = d_read | d_write;
    assign w_gnt_i = (r_state == ST_GNT_I);
    assign w_gnt_d = (r_state == ST_GNT_D);

    // Only meaningful in IDLE with at least one requester.
    always_comb begin
        w_pick_d = w_d_req;
        if (w_i_req && w_d_req) begin
            if (FIXED_PRI != 0) begin
                w_pick_d = 1'b1;
            end else begin
                w_pick_d = (r_last == C_LAST_I);
            end
        end
    end

    // Forwarding is decoded from state, so an async reset drops strobes at once.
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_gnt_i) begin
            mem_read = i_read;
            mem_addr = i_addr;
        end else if (w_gnt_d) begin
            mem_read  = d_read;
            mem_write = d_write;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end
    end

    assign i_ready  = w_gnt_i & w_i_req & mem_ready;
    assign d_ready  = w_gnt_d & w_d_req & mem_ready;
    assign i_rdata  = mem_rdata;
    assign d_rdata  = mem_rdata;
    assign i_grants = r_i_grants;
    assign d_grants = r_d_grants;

    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) begin
            r_state    <= ST_IDLE;
            r_last     <= C_LAST_I;
            r_i_grants <= '0;
            r_d_grants <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_i_req || w_d_req) begin
                        if (w_pick_d) begin
                            r_state    <= ST_GNT_D;
                            r_last     <= C_LAST_D;
                            r_d_grants <= r_d_grants + 32'd1;
                        end else begin
                            r_state    <= ST_GNT_I;
                            r_last     <= C_LAST_I;
                            r_i_grants <= r_i_grants + 32'd1;
                        end
                    end
                end
                ST_GNT_I: begin
                    if (!w_i_req) begin
                        r_state <= ST_IDLE;
                    end else if (mem_ready) begin
                        r_state <= ST_RELEASE;
                    end
                end
                ST_GNT_D: begin
                    if (!w_d_req) begin
                        r_state <= ST_IDLE;
                    end else if (mem_ready) begin
                        r_state <= ST_RELEASE;
                    end
                end
                // Absorbs the cycle in which the client still shows its request.
                ST_RELEASE: r_state <= ST_IDLE;
                default:    r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
